// File: rtl/sa_core_if.sv
// sa_core_if: operand input and result readout bundle for the systolic array core.
interface sa_core_if #(
    parameter int ROWS = 8
);
    logic [ROWS-1:0][7:0]  ainport;
    logic [ROWS-1:0][7:0]  winport;
    logic                  inpvalid;
    logic                  outread;
    logic [ROWS-1:0][31:0] routport;
    logic [ROWS-1:0]       rvalidport;

    modport master (
        output ainport, winport, inpvalid, outread,
        input  routport, rvalidport
    );

    modport slave (
        input  ainport, winport, inpvalid, outread,
        output routport, rvalidport
    );
endinterface

// File: rtl/sa_core.sv
// sa_core: output-stationary ROWS x ROWS systolic MAC array with a column-wise readout buffer.
// Define SA_CORE_SIGNED_EN for two's complement operands; unsigned otherwise.
module sa_core #(
    parameter int ROWS = 8,
    parameter int KLEN = 16
) (
    input  logic     clk,
    input  logic     rstn,
    sa_core_if.slave bus
);
    typedef enum logic [1:0] {COMPUTE, FLUSH, WAITBUF} state_e;

    localparam int TW = $clog2(KLEN + 1);
    localparam int FW = $clog2(2 * ROWS);
    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_e          state_q, state_d;
    logic [TW-1:0]   tile_q, tile_d;
    logic [FW-1:0]   flush_q, flush_d;
    logic            full_q;
    logic [CW-1:0]   col_q;
    logic            accept, load;
    logic [8:0]      ain [ROWS][ROWS];
    logic [8:0]      win [ROWS][ROWS];
    logic [31:0]     acc [ROWS][ROWS];
    logic [31:0]     buf_q [ROWS][ROWS];

    function automatic logic [31:0] mul(input logic [7:0] a, input logic [7:0] w);
`ifdef SA_CORE_SIGNED_EN
        logic signed [15:0] p;
        p = $signed({{8{a[7]}}, a}) * $signed({{8{w[7]}}, w});
        return {{16{p[15]}}, p};
`else
        logic [15:0] p;
        p = 16'(a) * 16'(w);
        return {16'b0, p};
`endif
    endfunction

    assign accept = bus.inpvalid && state_q == COMPUTE;
    assign load   = state_q == WAITBUF && !full_q;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= COMPUTE;
            tile_q  <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            tile_q  <= tile_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tile_d  = tile_q;
        flush_d = flush_q;
        case (state_q)
            COMPUTE: if (accept) begin
                tile_d  = tile_q + 1'b1;
                state_d = (tile_q == TW'(KLEN - 1)) ? FLUSH : COMPUTE;
            end
            FLUSH: begin
                flush_d = (flush_q == FW'(2 * ROWS - 1)) ? '0 : flush_q + 1'b1;
                state_d = (flush_q == FW'(2 * ROWS - 1)) ? WAITBUF : FLUSH;
            end
            WAITBUF: if (load) begin
                tile_d  = '0;
                state_d = COMPUTE;
            end
            default: state_d = COMPUTE;
        endcase
    end

    // Row i activations and column i weights are delayed i cycles so operands of one vector meet.
    for (genvar i = 0; i < ROWS; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign ain[0][0] = {accept, bus.ainport[0]};
            assign win[0][0] = {accept, bus.winport[0]};
        end else begin : g_shift
            logic [8:0] ash_q [i];
            logic [8:0] wsh_q [i];
            always_ff @(posedge clk or posedge rstn) begin
                if (rstn) begin
                    ash_q <= '{default: '0};
                    wsh_q <= '{default: '0};
                end else begin
                    ash_q[0] <= {accept, bus.ainport[i]};
                    wsh_q[0] <= {accept, bus.winport[i]};
                    for (int k = 1; k < i; k++) begin
                        ash_q[k] <= ash_q[k-1];
                        wsh_q[k] <= wsh_q[k-1];
                    end
                end
            end
            assign ain[i][0] = ash_q[i-1];
            assign win[0][i] = wsh_q[i-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < ROWS; j++) begin : g_pe
            logic [31:0] acc_q;
            always_ff @(posedge clk or posedge rstn) begin
                if (rstn)
                    acc_q <= '0;
                else if (load)
                    acc_q <= '0;
                else if (ain[i][j][8] && win[i][j][8])
                    acc_q <= acc_q + mul(ain[i][j][7:0], win[i][j][7:0]);
            end
            assign acc[i][j] = acc_q;
            if (j < ROWS - 1) begin : g_east
                logic [8:0] a_q;
                always_ff @(posedge clk or posedge rstn) begin
                    if (rstn)
                        a_q <= '0;
                    else
                        a_q <= ain[i][j];
                end
                assign ain[i][j+1] = a_q;
            end
            if (i < ROWS - 1) begin : g_south
                logic [8:0] w_q;
                always_ff @(posedge clk or posedge rstn) begin
                    if (rstn)
                        w_q <= '0;
                    else
                        w_q <= win[i][j];
                end
                assign win[i+1][j] = w_q;
            end
        end
    end

    // A load only happens with the buffer empty, so it can never collide with a read.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            buf_q  <= '{default: '0};
            full_q <= 1'b0;
            col_q  <= '0;
        end else if (load) begin
            buf_q  <= acc;
            full_q <= 1'b1;
            col_q  <= '0;
        end else if (bus.outread && full_q) begin
            full_q <= col_q != CW'(ROWS - 1);
            col_q  <= (col_q == CW'(ROWS - 1)) ? '0 : col_q + 1'b1;
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++)
            bus.routport[r] = full_q ? buf_q[r][col_q] : '0;
        bus.rvalidport = {ROWS{full_q}};
    end
endmodule

// File: tb/tb_sa_core.sv
// tb_sa_core: table-driven tile tests plus hand sequences for back-pressure, reset and long accumulation.
module tb_sa_core;
    localparam int R = 8;

`ifdef SA_CORE_SIGNED_EN
    localparam logic [31:0] E255 = 32'd16;
    localparam logic [31:0] EBIG = 32'd4200;
`else
    localparam logic [31:0] E255 = 32'd1040400;
    localparam logic [31:0] EBIG = 32'(64'd4200 * 64'd65025);
`endif

    typedef struct {
        bit          ramp;
        bit          alt;
        bit          lane;
        logic [7:0]  a;
        logic [7:0]  w;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    int   pass_n = 0;
    int   tot_n = 0;
    vec_t tbl [4];

    always #5 clk = ~clk;

    sa_core_if #(.ROWS(R)) bus ();
    sa_core_if #(.ROWS(2)) big ();

    sa_core #(.ROWS(R), .KLEN(16))   dut   (.clk(clk), .rstn(rstn), .bus(bus));
    sa_core #(.ROWS(2), .KLEN(4200)) u_big (.clk(clk), .rstn(rstn), .bus(big));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        tot_n++;
        if (got === want)
            pass_n++;
        else
            $display("FAIL %s: got %0d want %0d", name, got, want);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.inpvalid = 1'b0;
        bus.outread  = 1'b0;
        bus.ainport  = '0;
        bus.winport  = '0;
    endtask

    task automatic send(input vec_t v);
        for (int k = 0; k < 32; k++) begin
            if (!v.alt && k >= 16) break;
            bus.inpvalid = v.alt ? (k % 2 == 0) : 1'b1;
            for (int r = 0; r < R; r++) begin
                bus.ainport[r] = v.ramp ? 8'(k % 16) : v.lane ? 8'(v.a * (r + 1)) : v.a;
                bus.winport[r] = v.lane ? 8'(v.w * (r + 1)) : v.w;
            end
            step();
        end
        idle();
    endtask

    task automatic wait_valid(input int lat, input string name);
        int n = 0;
        while (bus.rvalidport == '0 && n < 100) begin
            step();
            n++;
        end
        chk({name, " latency"}, 64'(n), 64'(lat));
    endtask

    task automatic read_tile(input vec_t v, input string name);
        for (int c = 0; c < R; c++) begin
            chk($sformatf("%s rvalid c%0d", name, c), 64'(bus.rvalidport), 64'hFF);
            for (int r = 0; r < R; r++)
                chk($sformatf("%s r%0d c%0d", name, r, c), 64'(bus.routport[r]),
                    64'(v.lane ? 32'(v.exp * (r + 1) * (c + 1)) : v.exp));
            bus.outread = 1'b1;
            step();
            bus.outread = 1'b0;
        end
        chk({name, " empty rvalid"}, 64'(bus.rvalidport), 64'd0);
        chk({name, " empty rout"}, 64'(bus.routport == '0), 64'd1);
    endtask

    initial begin
        tbl[0] = '{ramp: 0, alt: 0, lane: 1, a: 1,   w: 1,   exp: 32'd16};
        tbl[1] = '{ramp: 1, alt: 0, lane: 0, a: 0,   w: 1,   exp: 32'd120};
        tbl[2] = '{ramp: 0, alt: 0, lane: 0, a: 255, w: 255, exp: E255};
        tbl[3] = '{ramp: 0, alt: 1, lane: 0, a: 2,   w: 3,   exp: 32'd96};
        idle();
        big.inpvalid = 1'b0;
        big.outread  = 1'b0;
        big.ainport  = '0;
        big.winport  = '0;
        #13;
        chk("reset rvalid", 64'(bus.rvalidport), 64'd0);
        chk("reset rout", 64'(bus.routport == '0), 64'd1);
        rstn = 1'b0;
        step();
        bus.outread = 1'b1;
        repeat (2) step();
        bus.outread = 1'b0;
        chk("idle read ignored", 64'(bus.rvalidport), 64'd0);

        for (int i = 0; i < 4; i++) begin
            send(tbl[i]);
            wait_valid(tbl[i].alt ? 16 : 17, $sformatf("tbl%0d", i));
            read_tile(tbl[i], $sformatf("tbl%0d", i));
        end

        // Second tile completes while the first is still unread; late vectors must be dropped.
        begin
            vec_t t1 = '{ramp: 0, alt: 0, lane: 0, a: 3, w: 5, exp: 32'd240};
            vec_t t2 = '{ramp: 0, alt: 0, lane: 0, a: 1, w: 1, exp: 32'd16};
            send(t1);
            wait_valid(17, "hold1");
            send(t2);
            bus.inpvalid = 1'b1;
            bus.ainport  = {R{8'd100}};
            bus.winport  = {R{8'd100}};
            repeat (40) step();
            idle();
            chk("hold rvalid", 64'(bus.rvalidport), 64'hFF);
            chk("hold data", 64'(bus.routport[0]), 64'd240);
            read_tile(t1, "hold1");
            wait_valid(1, "reload");
            read_tile(t2, "hold2");
        end

        begin
            vec_t t3 = '{ramp: 0, alt: 0, lane: 0, a: 2, w: 2, exp: 32'd64};
            vec_t t4 = '{ramp: 0, alt: 0, lane: 0, a: 1, w: 2, exp: 32'd32};
            send(t3);
            wait_valid(17, "rst tile");
            repeat (3) begin
                bus.outread = 1'b1;
                step();
            end
            bus.outread = 1'b0;
            chk("col3 data", 64'(bus.routport[7]), 64'd64);
            #2 rstn = 1'b1;
            #1;
            chk("async rst rvalid", 64'(bus.rvalidport), 64'd0);
            chk("async rst rout", 64'(bus.routport == '0), 64'd1);
            step();
            rstn = 1'b0;
            step();
            bus.inpvalid = 1'b1;
            bus.ainport  = {R{8'd9}};
            bus.winport  = {R{8'd9}};
            repeat (5) step();
            idle();
            rstn = 1'b1;
            #2 rstn = 1'b0;
            step();
            send(t4);
            wait_valid(17, "post rst");
            read_tile(t4, "post rst");
        end

        begin
            int n = 0;
            big.ainport  = {2{8'd255}};
            big.winport  = {2{8'd255}};
            big.inpvalid = 1'b1;
            repeat (4200) step();
            big.inpvalid = 1'b0;
            while (big.rvalidport == '0 && n < 100) begin
                step();
                n++;
            end
            chk("big latency", 64'(n), 64'd5);
            for (int c = 0; c < 2; c++) begin
                chk($sformatf("big rvalid c%0d", c), 64'(big.rvalidport), 64'd3);
                for (int r = 0; r < 2; r++)
                    chk($sformatf("big r%0d c%0d", r, c), 64'(big.routport[r]), 64'(EBIG));
                big.outread = 1'b1;
                step();
                big.outread = 1'b0;
            end
            chk("big empty", 64'(big.rvalidport), 64'd0);
        end

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
